// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the multi-digit decimal counter.
package bcd_pkg;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction
endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with clear, load and a 9<->0 wrapping step in either direction.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    input  logic             step,
    input  logic             up,
    output logic [BCD_W-1:0] q,
    output logic             at_max,
    output logic             at_min
);
    logic [BCD_W-1:0] digit_d, digit_q;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = BCD_MIN;
        end else if (ld) begin
            digit_d = ld_val;
        end else if (step) begin
            if (up) begin
                digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign q      = digit_q;
    assign at_max = (digit_q == BCD_MAX);
    assign at_min = (digit_q == BCD_MIN);
endmodule

// File: rtl/bcd_counter_n.sv
// DIGITS-wide BCD up/down counter with clear, validated load and one-cycle tc / load_err pulses.
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    input  logic                    en,
    input  logic                    up,
    output logic [BCD_W*DIGITS-1:0] q,
    output logic                    tc,
    output logic                    load_err
);
    logic [DIGITS-1:0] at_max, at_min, step;
    logic [DIGITS:0]   chain;
    logic              ld_valid, load_ok, count;
    logic              tc_d, tc_q, load_err_d, load_err_q;

    // A load is accepted only if every nibble is a legal decimal digit.
    always_comb begin
        ld_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_valid(load_val[i*BCD_W +: BCD_W])) begin
                ld_valid = 1'b0;
            end
        end
    end

    assign count   = en & ~clr & ~load;
    assign load_ok = load & ld_valid;

    // chain[i] is high when every digit below i sits at its wrap value for the current direction.
    assign chain[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign chain[i+1] = chain[i] & (up ? at_max[i] : at_min[i]);
        assign step[i]    = count & chain[i];

        bcd_digit u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (clr),
            .ld     (load_ok),
            .ld_val (load_val[i*BCD_W +: BCD_W]),
            .step   (step[i]),
            .up     (up),
            .q      (q[i*BCD_W +: BCD_W]),
            .at_max (at_max[i]),
            .at_min (at_min[i])
        );
    end

    always_comb begin
        tc_d       = count & chain[DIGITS];
        load_err_d = ~clr & load & ~ld_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign tc       = tc_q;
    assign load_err = load_err_q;
endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n (DIGITS=4): directed scenarios plus random traffic against an integer model.
module tb_bcd_counter_n;
  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;
  localparam int MODV = 10000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic [W-1:0] q;
  logic         tc;
  logic         load_err;

  int n_tests = 0;
  int n_fail = 0;

  int m_val = 0;
  bit m_tc = 1'b0;
  bit m_err = 1'b0;

  bcd_counter_n #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .q(q), .tc(tc), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [W-1:0] b);
    for (int i = 0; i < DIGITS; i++) if (b[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] b);
    int v;
    int scale;
    v = 0;
    scale = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v = v + int'(b[i*4 +: 4]) * scale;
      scale = scale * 10;
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"}, 32'(q), 32'(to_bcd(m_val)));
    check({tag, ".tc"}, 32'(tc), 32'(m_tc));
    check({tag, ".load_err"}, 32'(load_err), 32'(m_err));
  endtask

  // Drive one cycle of inputs, advance the model by the same edge, then compare.
  task automatic cycle(input string tag, input bit c, input bit l, input logic [W-1:0] lv,
                       input bit e, input bit u);
    clr = c; load = l; load_val = lv; en = e; up = u;
    @(posedge clk);
    m_tc = 1'b0;
    m_err = 1'b0;
    if (c) begin
      m_val = 0;
    end else if (l) begin
      if (bcd_ok(lv)) m_val = from_bcd(lv);
      else m_err = 1'b1;
    end else if (e) begin
      if (u) begin
        m_tc = (m_val == MODV - 1);
        m_val = (m_val + 1) % MODV;
      end else begin
        m_tc = (m_val == 0);
        m_val = (m_val + MODV - 1) % MODV;
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] rv;
    #2;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("hold_after_reset", 0, 0, '0, 0, 1);

    // Long up-count across a full wrap.
    cycle("load_9950", 0, 1, 16'h9950, 0, 1);
    for (int i = 0; i < 60; i++) cycle("count_up", 0, 0, '0, 1, 1);

    // Down from zero wraps to all-9.
    cycle("load_0000", 0, 1, 16'h0000, 0, 0);
    cycle("down_wrap", 0, 0, '0, 1, 0);
    cycle("down_9998", 0, 0, '0, 1, 0);
    cycle("load_1000", 0, 1, 16'h1000, 0, 0);
    cycle("down_borrow", 0, 0, '0, 1, 0);

    // Rejected load holds q.
    cycle("load_0042", 0, 1, 16'h0042, 0, 1);
    cycle("load_bad", 0, 1, 16'h12A4, 0, 1);
    cycle("load_good", 0, 1, 16'h1234, 0, 1);

    // Priority clr > load > en.
    cycle("load_0057", 0, 1, 16'h0057, 0, 1);
    cycle("clr_wins", 1, 1, 16'h0321, 1, 1);
    cycle("load_beats_en", 0, 1, 16'h0321, 1, 1);

    // Direction toggling and hold.
    cycle("load_0009", 0, 1, 16'h0009, 0, 1);
    cycle("toggle_up", 0, 0, '0, 1, 1);
    cycle("toggle_down", 0, 0, '0, 1, 0);
    cycle("toggle_up2", 0, 0, '0, 1, 1);
    for (int i = 0; i < 3; i++) cycle("hold", 0, 0, '0, 0, $urandom_range(0, 1));

    // Random traffic, biased toward wrap boundaries.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: rv = W'($urandom);
        1: rv = to_bcd($urandom_range(0, 1) ? $urandom_range(9990, 9999) : $urandom_range(0, 9));
        default: rv = to_bcd($urandom_range(0, MODV - 1));
      endcase
      cycle("random", ($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0), rv,
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1));
    end

    // Asynchronous reset while tc is high.
    cycle("load_0000b", 0, 1, 16'h0000, 0, 0);
    cycle("pre_reset_wrap", 0, 0, '0, 1, 0);
    #3;
    rst_n = 1'b0;
    m_val = 0; m_tc = 1'b0; m_err = 1'b0;
    #1;
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("after_reset", 0, 0, '0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
